// File: rtl/rr_select_pkg.sv
// Shared types and constants for the 4-source round-robin mux-select arbiter.
package rr_select_pkg;

  localparam int N_SRC = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_SRC-1:0] sel2onehot(input logic [SEL_W-1:0] sel);
    logic [N_SRC-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_select_if.sv
// Request/ack in, mux select + grant out, between sources and the arbiter.
interface rr_select_if;
  import rr_select_pkg::*;

  logic [N_SRC-1:0] req;
  logic             ack;
  logic             s0;
  logic             s1;
  logic [N_SRC-1:0] gnt;
  logic             valid;

  modport master (
    output req, ack,
    input  s0, s1, gnt, valid
  );

  modport slave (
    input  req, ack,
    output s0, s1, gnt, valid
  );

endinterface

// File: rtl/rr_select_pick.sv
// Combinational round-robin pick: first requester after 'last', wrapping to 'last'.
module rr_pick_4
  import rr_select_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] cand;
  logic             found;

  always_comb begin
    idx   = last;
    cand  = '0;
    found = 1'b0;
    any   = |req;
    // offsets 1..4 visit last+1 .. last+3 and finally last itself
    for (int unsigned off = 1; off <= N_SRC; off++) begin
      cand = last + SEL_W'(off);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_select_4.sv
// Round-robin arbiter driving the {s0,s1} select of a 4:1 mux, with bounded bursts.
module rr_select_4
  import rr_select_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_select_if.slave  bus
);

  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] sel;
  logic [N_SRC-1:0] gnt;
  logic             valid;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick_4 u_pick (
    .req  (bus.req),
    .last (last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= '1;
      sel   <= '0;
      gnt   <= '0;
      valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            sel   <= pick_idx;
            gnt   <= sel2onehot(pick_idx);
            cnt   <= '0;
            valid <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          // a dropped request releases even if the same cycle carried an ack
          if (!bus.req[sel] || (bus.ack && cnt == CNT_LAST)) begin
            last  <= sel;
            gnt   <= '0;
            valid <= 1'b0;
            state <= IDLE;
          end else if (bus.ack) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s0    = sel[1];
  assign bus.s1    = sel[0];
  assign bus.gnt   = gnt;
  assign bus.valid = valid;

endmodule

// File: tb/tb_rr_select_4.sv
// Scoreboard bench: four arbiters (BURST=1..4) share req/ack; a tenure model predicts outputs.
module tb_rr_select_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       ack = 1'b0;

  always #5 clk = ~clk;

  logic       av[4];
  logic [3:0] ag[4];
  logic [1:0] asel[4];

  for (genvar i = 0; i < 4; i++) begin : g_dut
    rr_select_if bus ();
    assign bus.req = req;
    assign bus.ack = ack;
    rr_select_4 #(.BURST(i + 1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign av[i]   = bus.valid;
    assign ag[i]   = bus.gnt;
    assign asel[i] = {bus.s0, bus.s1};
  end

  typedef struct packed {
    logic [3:0]       v;
    logic [3:0][3:0]  g;
    logic [3:0][1:0]  s;
    logic             cs;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // reference: one "tenure" per source, counted in whole acked beats
  int busy[4], owner[4], beats[4], last[4];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      busy[i] = 0; owner[i] = 0; beats[i] = 0; last[i] = 3;
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic a);
    for (int i = 0; i < 4; i++) begin
      if (busy[i] == 0) begin
        for (int d = 1; d <= 4; d++) begin
          int k;
          k = (last[i] + d) % 4;
          if (busy[i] == 0 && r[k]) begin
            busy[i] = 1; owner[i] = k; beats[i] = 0;
          end
        end
      end else if (!r[owner[i]]) begin
        busy[i] = 0; last[i] = owner[i];
      end else if (a) begin
        beats[i]++;
        if (beats[i] == i + 1) begin
          busy[i] = 0; last[i] = owner[i];
        end
      end
    end
  endtask

  task automatic push_expect(input logic in_reset);
    exp_t e;
    e = '0;
    e.cs = in_reset;
    for (int i = 0; i < 4; i++) begin
      e.v[i] = (busy[i] != 0);
      e.g[i] = busy[i] != 0 ? 4'(1 << owner[i]) : 4'b0000;
      e.s[i] = 2'(owner[i]);
    end
    exp_q.push_back(e);
  endtask

  // drive at the current negedge, consume one rising edge, return at the next negedge
  task automatic cyc(input logic [3:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(r, a);
    push_expect(!rst_n);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("valid[B%0d]", i + 1), int'(av[i]), int'(e.v[i]));
        chk($sformatf("gnt[B%0d]", i + 1), int'(ag[i]), int'(e.g[i]));
        if (e.v[i] || e.cs)
          chk($sformatf("sel[B%0d]", i + 1), int'(asel[i]), int'(e.cs ? 2'b00 : e.s[i]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic       a;
    model_reset();

    repeat (3) cyc(4'b0100, 1'b1);
    rst_n = 1'b1;
    repeat (14) cyc(4'b0100, 1'b1);

    repeat (24) cyc(4'b1111, 1'b1);

    repeat (3) cyc(4'b0000, 1'b0);
    for (int c = 0; c < 24; c++) cyc(4'b0011, c[0] == 1'b0);

    repeat (3) cyc(4'b0000, 1'b0);
    cyc(4'b0010, 1'b1);
    cyc(4'b0010, 1'b1);
    repeat (4) cyc(4'b1100, 1'b1);

    repeat (3) cyc(4'b1111, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("async_valid[B%0d]", i + 1), int'(av[i]), 0);
      chk($sformatf("async_gnt[B%0d]", i + 1), int'(ag[i]), 0);
    end
    @(negedge clk);
    repeat (2) cyc(4'b1010, 1'b1);
    rst_n = 1'b1;
    repeat (6) cyc(4'b1010, 1'b1);

    repeat (4) cyc(4'b0000, 1'b1);
    repeat (8) cyc(4'b1001, 1'b1);

    r = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) != 0);
      cyc(r, a);
    end

    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
